// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU op sequencer.
// ALU function codes, opcodes, FSM states and the decode bundle.
package alu_pkg;

  localparam logic [4:0] ALU_F_PASS = 5'b00000;
  localparam logic [4:0] ALU_F_ADD  = 5'b10010;
  localparam logic [4:0] ALU_F_SUB  = 5'b01100;
  localparam logic [4:0] ALU_F_NOT  = 5'b00001;
  localparam logic [4:0] ALU_F_XOR  = 5'b01111;
  localparam logic [4:0] ALU_F_AND  = 5'b10111;
  localparam logic [4:0] ALU_F_OR   = 5'b11101;
  localparam logic [4:0] ALU_F_SHL  = 5'b00001;
  localparam logic [4:0] ALU_F_SHR  = 5'b00000;

  localparam logic ALU_FSEL_181 = 1'b0;
  localparam logic ALU_FSEL_SHF = 1'b1;
  localparam logic ALU_CSEL_U   = 1'b0;
  localparam logic ALU_CSEL_F   = 1'b1;

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_SBC = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] f;
    logic       fsel;
    logic       csel;
    logic       ucin;
    logic       upd_c;
    logic       upd_z;
    logic       wr;
    logic       err;
  } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode to ALU control / flag-update / writeback decode.
// Purely combinational; illegal opcodes decode to idle controls.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0] op_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '{f: ALU_F_PASS, fsel: ALU_FSEL_181,
              csel: ALU_CSEL_U, ucin: 1'b0,
              upd_c: 1'b0, upd_z: 1'b0,
              wr: 1'b0, err: 1'b1};
    unique case (1'b1)
      (op_i == OP_MOV): begin
        dec_o.err = 1'b0;
        dec_o.wr  = 1'b1;
      end
      (op_i == OP_ADD),
      (op_i == OP_ADC): begin
        dec_o.f     = ALU_F_ADD;
        dec_o.csel  = (op_i == OP_ADC);
        dec_o.upd_c = 1'b1;
        dec_o.upd_z = 1'b1;
        dec_o.wr    = 1'b1;
        dec_o.err   = 1'b0;
      end
      (op_i == OP_SUB),
      (op_i == OP_SBC),
      (op_i == OP_CMP): begin
        // SUB/CMP force carry-in=1 so C means no borrow
        dec_o.f     = ALU_F_SUB;
        dec_o.csel  = (op_i == OP_SBC);
        dec_o.ucin  = (op_i != OP_SBC);
        dec_o.upd_c = 1'b1;
        dec_o.upd_z = 1'b1;
        dec_o.wr    = (op_i != OP_CMP);
        dec_o.err   = 1'b0;
      end
      (op_i == OP_NOT),
      (op_i == OP_XOR),
      (op_i == OP_AND),
      (op_i == OP_OR): begin
        dec_o.f     = (op_i == OP_NOT) ? ALU_F_NOT :
                      (op_i == OP_XOR) ? ALU_F_XOR :
                      (op_i == OP_AND) ? ALU_F_AND :
                                         ALU_F_OR;
        dec_o.upd_z = 1'b1;
        dec_o.wr    = 1'b1;
        dec_o.err   = 1'b0;
      end
      (op_i == OP_SHL),
      (op_i == OP_SHR): begin
        dec_o.f     = (op_i == OP_SHL) ? ALU_F_SHL
                                       : ALU_F_SHR;
        dec_o.fsel  = ALU_FSEL_SHF;
        dec_o.upd_z = 1'b1;
        dec_o.wr    = 1'b1;
        dec_o.err   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_seq.sv
// ALU op sequencer: issues one op to the ALU for a single cycle,
// captures result and C/Z flags, returns them via valid/ready.
module alu_op_seq
  import alu_pkg::*;
#(
  parameter int         WIDTH  = 16,
  parameter logic [4:0] IDLE_F = 5'b00000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic             res_wr,
  output logic             res_err,
  output logic [4:0]       alu_f,
  output logic             alu_fsel,
  output logic             alu_csel,
  output logic             alu_ucin,
  output logic             alu_fcin,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_zout,
  input  logic             flags_we,
  input  logic [1:0]       flags_d,
  output logic             flag_c,
  output logic             flag_z
);

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] res_y_q;
  logic             res_wr_q, res_err_q;
  logic             c_q, z_q;
  dec_t             dec;

  alu_op_decode u_dec (
    .op_i  (op_q),
    .dec_o (dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    res_valid = (state_q == ST_RESP);
    alu_f     = IDLE_F;
    alu_fsel  = ALU_FSEL_181;
    alu_csel  = ALU_CSEL_U;
    alu_ucin  = 1'b0;
    if (state_q == ST_EXEC && !dec.err) begin
      alu_f    = dec.f;
      alu_fsel = dec.fsel;
      alu_csel = dec.csel;
      alu_ucin = dec.ucin;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= OP_MOV;
      res_y_q   <= '0;
      res_wr_q  <= 1'b0;
      res_err_q <= 1'b0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        if (req_valid) op_q <= req_op;
        if (flags_we) begin
          c_q <= flags_d[1];
          z_q <= flags_d[0];
        end
      end
      // logic/shift ops leave a stale cout, so C is gated by upd_c
      if (state_q == ST_EXEC) begin
        res_y_q   <= alu_y;
        res_wr_q  <= dec.wr;
        res_err_q <= dec.err;
        if (dec.upd_c) c_q <= alu_cout;
        if (dec.upd_z) z_q <= alu_zout;
      end
    end
  end

  assign res_y    = res_y_q;
  assign res_wr   = res_wr_q;
  assign res_err  = res_err_q;
  assign flag_c   = c_q;
  assign flag_z   = z_q;
  assign alu_fcin = c_q;

endmodule

// File: tb/tb_alu_op_seq.sv
// Bench for alu_op_seq: behavioural ALU, directed table,
// reset-mid-EXEC sequence and randomized ops against a model.
module tb_alu_op_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic        res_valid, res_ready;
  logic [15:0] res_y;
  logic        res_wr, res_err;
  logic [4:0]  alu_f;
  logic        alu_fsel, alu_csel, alu_ucin, alu_fcin;
  logic [15:0] alu_y;
  logic        alu_cout, alu_zout;
  logic        flags_we;
  logic [1:0]  flags_d;
  logic        flag_c, flag_z;

  logic [15:0] alu_a, alu_b;
  logic        stale_c;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        m_c, m_z;

  always #5 clk = ~clk;

  alu_op_seq #(.WIDTH(16), .IDLE_F(5'b00000)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_wr(res_wr), .res_err(res_err),
    .alu_f(alu_f), .alu_fsel(alu_fsel),
    .alu_csel(alu_csel), .alu_ucin(alu_ucin),
    .alu_fcin(alu_fcin),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_zout(alu_zout),
    .flags_we(flags_we), .flags_d(flags_d),
    .flag_c(flag_c), .flag_z(flag_z)
  );

  // Behavioural ALU driven by the DUT's controls
  always_comb begin
    logic cin;
    cin      = alu_csel ? alu_fcin : alu_ucin;
    alu_y    = alu_a;
    alu_cout = stale_c;
    if (alu_fsel) begin
      alu_y = (alu_f == 5'b00001) ? (alu_a << 1) : (alu_a >> 1);
    end else begin
      case (alu_f)
        5'b10010: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b}
                                      + {16'd0, cin};
        5'b01100: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, ~alu_b}
                                      + {16'd0, cin};
        5'b00001: alu_y = ~alu_a;
        5'b01111: alu_y = alu_a ^ alu_b;
        5'b10111: alu_y = alu_a & alu_b;
        5'b11101: alu_y = alu_a | alu_b;
        default:  alu_y = alu_a;
      endcase
    end
    alu_zout = (alu_y == 16'd0);
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        fwe;
    logic [1:0]  fd;
    int          bp;
    logic        chk_ctl;
    logic [15:0] y;
    logic        c, z, wr, err;
    logic [4:0]  f;
    logic        fsel, csel, ucin, fcin;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Architectural meaning of each opcode, C=1 means no borrow
  task automatic ref_op(input logic [3:0] op,
                        input logic [15:0] a, b,
                        inout logic c, z,
                        output logic [15:0] y,
                        output logic wr, err);
    int s;
    int bw;
    wr  = 1'b1;
    err = 1'b0;
    y   = 16'd0;
    case (op)
      4'd0: y = a;
      4'd1, 4'd2: begin
        s = int'(a) + int'(b) + ((op == 4'd2) ? int'(c) : 0);
        y = s[15:0];
        c = (s > 65535);
      end
      4'd3, 4'd4, 4'd5: begin
        bw = (op == 4'd4) ? int'(!c) : 0;
        s  = int'(a) - int'(b) - bw;
        y  = s[15:0];
        c  = (s >= 0);
        wr = (op != 4'd5);
      end
      4'd6:  y = ~a;
      4'd7:  y = a ^ b;
      4'd8:  y = a & b;
      4'd9:  y = a | b;
      4'd10: y = {a[14:0], 1'b0};
      4'd11: y = {1'b0, a[15:1]};
      default: begin
        wr  = 1'b0;
        err = 1'b1;
      end
    endcase
    if (op <= 4'd11 && op != 4'd0) z = (y == 16'd0);
  endtask

  task automatic run_vec(input vec_t v, input bit use_model);
    int n;
    logic [15:0] my, hy;
    logic mwr, merr, hc, hz;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk("req_ready wait", req_ready, 1);
    req_valid = 1'b1;
    req_op    = v.op;
    alu_a     = v.a;
    alu_b     = v.b;
    flags_we  = v.fwe;
    flags_d   = v.fd;
    if (v.fwe) {m_c, m_z} = v.fd;
    stale_c = ~m_c;
    @(posedge clk); #1;
    req_valid = 1'b0;
    flags_we  = 1'b0;
    chk("exec fcin", alu_fcin, m_c);
    chk("exec req_ready", req_ready, 0);
    chk("exec res_valid", res_valid, 0);
    if (v.chk_ctl) begin
      chk("exec f", alu_f, v.f);
      chk("exec fsel", alu_fsel, v.fsel);
      chk("exec csel", alu_csel, v.csel);
      if (!v.csel) chk("exec ucin", alu_ucin, v.ucin);
      chk("exec fcin tbl", alu_fcin, v.fcin);
    end
    ref_op(v.op, v.a, v.b, m_c, m_z, my, mwr, merr);
    if (use_model) begin
      v.y = my; v.c = m_c; v.z = m_z;
      v.wr = mwr; v.err = merr;
    end
    @(posedge clk); #1;
    chk("res_valid", res_valid, 1);
    if (!v.err) chk("res_y", res_y, v.y);
    chk("res_wr", res_wr, v.wr);
    chk("res_err", res_err, v.err);
    chk("flag_c", flag_c, v.c);
    chk("flag_z", flag_z, v.z);
    hy = res_y; hc = flag_c; hz = flag_z;
    for (int i = 0; i < v.bp; i++) begin
      req_valid = 1'b1;
      req_op    = 4'd1;
      alu_a     = 16'($urandom);
      @(posedge clk); #1;
      chk("bp res_valid", res_valid, 1);
      chk("bp res_y", res_y, hy);
      chk("bp req_ready", req_ready, 0);
      chk("bp flags", {flag_c, flag_z}, {hc, hz});
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("post res_valid", res_valid, 0);
    chk("post req_ready", req_ready, 1);
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 4'd0;
    res_ready = 1'b0; flags_we = 1'b0; flags_d = 2'b00;
    alu_a = 16'd0; alu_b = 16'd0; stale_c = 1'b0;
    m_c = 1'b0; m_z = 1'b0;

    //          op    a        b        fwe fd    bp ctl
    //          y        c  z  wr err f         fsel csel ucin fcin
    tbl[0] = '{4'd1, 16'hFFFF, 16'h0001, 0, 2'b00, 0, 1,
               16'h0000, 1, 1, 1, 0, 5'b10010, 0, 0, 0, 0};
    tbl[1] = '{4'd2, 16'h0000, 16'h0000, 0, 2'b00, 0, 1,
               16'h0001, 0, 0, 1, 0, 5'b10010, 0, 1, 0, 1};
    tbl[2] = '{4'd5, 16'h0005, 16'h0005, 0, 2'b00, 0, 1,
               16'h0000, 1, 1, 0, 0, 5'b01100, 0, 0, 1, 0};
    tbl[3] = '{4'd10, 16'h8001, 16'h0001, 0, 2'b00, 0, 1,
               16'h0002, 1, 0, 1, 0, 5'b00001, 1, 0, 0, 1};
    tbl[4] = '{4'd1, 16'h0001, 16'h0002, 0, 2'b00, 5, 1,
               16'h0003, 0, 0, 1, 0, 5'b10010, 0, 0, 0, 1};
    tbl[5] = '{4'd4, 16'h0003, 16'h0001, 1, 2'b10, 0, 1,
               16'h0002, 1, 0, 1, 0, 5'b01100, 0, 1, 0, 1};
    tbl[6] = '{4'hE, 16'h0007, 16'h0007, 0, 2'b00, 0, 1,
               16'h0000, 1, 0, 0, 1, 5'b00000, 0, 0, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst res_valid", res_valid, 0);
    chk("rst req_ready", req_ready, 1);
    chk("rst res_y", res_y, 0);
    chk("rst flags", {flag_c, flag_z}, 0);
    chk("rst alu_f", alu_f, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) run_vec(tbl[i], 1'b0);

    // Reset while an ADD is in EXEC
    req_valid = 1'b1; req_op = 4'd1;
    alu_a = 16'h0001; alu_b = 16'h0001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pre-rst alu_f", alu_f, 5'b10010);
    reset = 1'b1;
    #1;
    chk("mid-rst alu_f", alu_f, 0);
    chk("mid-rst ctl", {alu_fsel, alu_csel, alu_ucin}, 0);
    chk("mid-rst flags", {flag_c, flag_z}, 0);
    chk("mid-rst res", {res_valid, res_wr, res_err}, 0);
    chk("mid-rst res_y", res_y, 0);
    chk("mid-rst req_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    m_c = 1'b0; m_z = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post-rst res_valid", res_valid, 0);
    end

    for (int i = 0; i < 80; i++) begin
      rv = '{default: '0};
      rv.op  = 4'($urandom_range(0, 15));
      rv.b   = 16'($urandom);
      rv.a   = ($urandom_range(0, 3) == 0) ? rv.b : 16'($urandom);
      rv.fwe = ($urandom_range(0, 3) == 0);
      rv.fd  = 2'($urandom);
      rv.bp  = $urandom_range(0, 2);
      run_vec(rv, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_seq.md
Name: alu_op_seq

Overview:
Initiator side of the ALU control interface. It accepts one abstract opcode per request and drives the ALU controls `f`, `fsel`, `csel`, `ucin` and `fcin` for exactly one execute cycle. It then captures the ALU result `y` and the `cout`/`zout` outputs into a result register and the C/Z flag register, and returns them through a valid/ready handshake. It sits between the instruction sequencer and the combinational ALU. It owns the architectural carry/zero flags and feeds carry back as `fcin`.

Parameters:
- WIDTH, 16, data width of `alu_y` and `res_y`; only 16 is supported by the ALU.
- IDLE_F, 5'b00000, ALU function driven whenever no op is executing (pass-A).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  opcode request present
- req_ready  out  1  block can accept a request (IDLE only)
- req_op  in  4  opcode: 0 MOV, 1 ADD, 2 ADC, 3 SUB, 4 SBC, 5 CMP, 6 NOT, 7 XOR, 8 AND, 9 OR, 10 SHL, 11 SHR, 12-15 illegal
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_y  out  WIDTH  captured ALU result
- res_wr  out  1  result must be written back (0 for CMP and illegal ops)
- res_err  out  1  op was illegal
- alu_f  out  5  ALU function code
- alu_fsel  out  1  0 = 74181 path, 1 = shifter
- alu_csel  out  1  0 = use ucin, 1 = use fcin
- alu_ucin  out  1  unconditional carry-in
- alu_fcin  out  1  flag carry-in; always equals flag_c
- alu_y  in  WIDTH  ALU result (combinational)
- alu_cout  in  1  ALU carry out
- alu_zout  in  1  ALU zero out
- flags_we  in  1  load flags from flags_d (honoured in IDLE only)
- flags_d  in  2  {C,Z} load value
- flag_c  out  1  carry flag
- flag_z  out  1  zero flag

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_op and move to EXEC.
  - flags_we loads {flag_c, flag_z} at the same edge. When it coincides with acceptance, the accepted op sees the new C.
- EXEC (exactly 1 cycle):
  - ALU controls are decoded from the latched op.
  - At the closing edge: res_y<=alu_y; flags updated per the op rules below; move to RESP.
  - flags_we is ignored.
- RESP:
  - res_valid=1; res_y, res_wr and res_err are held stable until res_ready.
  - On res_ready, move to IDLE.
  - req_ready=0 in EXEC and RESP.
- Latency: request accepted at edge N; res_valid high after edge N+1. Minimum 3 cycles per op.
- ALU control by op (f / fsel / csel / ucin):
  - MOV: 00000/0/0/0
  - ADD: 10010/0/0/0
  - ADC: 10010/0/1/x
  - SUB and CMP: 01100/0/0/1
  - SBC: 01100/0/1/x
  - NOT: 00001/0/0/0
  - XOR: 01111/0/0/0
  - AND: 10111/0/0/0
  - OR: 11101/0/0/0
  - SHL: 00001/1/0/0
  - SHR: 00000/1/0/0
- Outside EXEC, and for illegal ops: IDLE_F, fsel=0, csel=0, ucin=0.
- Carry convention: C=1 means no borrow on subtraction. SBC borrows when C=0.
- Flag update rules:
  - ADD, ADC, SUB, SBC, CMP: C<=alu_cout, Z<=alu_zout.
  - NOT, XOR, AND, OR, SHL, SHR: Z only; C unchanged. The ALU's cout is stale on these ops and must not be sampled.
  - MOV and illegal ops: no flag change.
- res_wr=1 for every legal op except CMP.
- Illegal op: res_err=1, res_wr=0, res_y=alu_y (don't-care), flags unchanged.
- Reset (asynchronous, any state, including mid-EXEC): state<=IDLE; res_y=0; res_valid=0; res_wr=0; res_err=0; flag_c=0; flag_z=0; pending op discarded. ALU controls return to idle values immediately.
- req_valid arriving outside IDLE is not accepted. The requester must hold req_op stable until req_ready.

Decomposition:
- Shared package alu_pkg:
  - ALU_F_* function codes, ALU_FSEL_*/ALU_CSEL_* selects.
  - Opcode constants OP_MOV..OP_SHR.
  - State encoding.
- One natural sub-module, alu_op_decode: combinational, op -> {f, fsel, csel, ucin, upd_c, upd_z, wr, err}. It is instantiated once on the latched op.

Test Plan:
1. ADD with bench ALU a=16'hFFFF, b=16'h0001 -> during EXEC alu_f=10010, csel=0, ucin=0; res_y=16'h0000, C=1, Z=1, res_wr=1, res_valid one cycle after acceptance.
2. ADC immediately after (1), a=0, b=0 -> csel=1, fcin=1; res_y=16'h0001, C=0, Z=0.
3. CMP a=5, b=5, then SHL a=16'h8001, b=1 -> CMP: ucin=1, res_wr=0, C=1, Z=1. SHL: fsel=1, f=00001, res_y=16'h0002, Z=0, C stays 1.
4. Backpressure: hold res_ready=0 for 5 cycles after a result -> res_valid, res_y and flags stable; req_ready=0; a new req_valid is not accepted until RESP exits.
5. flags_we with flags_d=2'b10 in the same IDLE cycle as an SBC request, a=3, b=1 -> SBC uses fcin=1; res_y=16'h0002, C=1, Z=0.
6. Illegal op 4'hE -> res_err=1, res_wr=0, flags unchanged. Assert reset mid-EXEC of a second op -> all outputs and flags are 0 immediately, state IDLE, no res_valid.
